// File: rtl/cache_refill_ctrl.sv
// Miss-handling refill controller: passes hits, fetches a 4-word line on a miss and fills the cache.
// Define REFILL_STATS_EN to implement the hit/miss counters; otherwise they read as zero.
module cache_refill_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [14:0]  req_addr,
  output logic         req_ready,
  input  logic         hit,
  output logic         mem_rd,
  output logic [12:0]  mem_addr,
  input  logic         mem_valid,
  input  logic [127:0] mem_data,
  output logic         fill_we,
  output logic [2:0]   fill_tag,
  output logic [9:0]   fill_index,
  output logic [127:0] fill_data,
  output logic         busy,
  output logic         err,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int unsigned TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_e;

  state_e               state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 mem_rd_q;
  logic [12:0]          mem_addr_q;
  logic                 fill_we_q;
  logic [2:0]           fill_tag_q;
  logic [9:0]           fill_index_q;
  logic [127:0]         fill_data_q;
  logic                 err_q;

  // Word offset only selects within the line; the controller works on whole lines.
  logic unused_offset;
  assign unused_offset = ^req_addr[1:0];

  // mem_addr_q doubles as the latched miss address ({tag,index}) for the fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      fill_we_q    <= 1'b0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      fill_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      fill_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && !hit) begin
            mem_addr_q <= req_addr[14:2];
            mem_rd_q   <= 1'b1;
            timer_q    <= '0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          timer_q <= timer_q + TIMER_W'(1);
          if (mem_valid) begin
            fill_data_q  <= mem_data;
            fill_tag_q   <= mem_addr_q[12:10];
            fill_index_q <= mem_addr_q[9:0];
            fill_we_q    <= 1'b1;
            mem_rd_q     <= 1'b0;
            state_q      <= FILL;
          end else if (timer_q == TIMER_W'(TIMEOUT)) begin
            err_q    <= 1'b1;
            mem_rd_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        FILL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && hit;
  assign busy       = (state_q != IDLE);
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign fill_we    = fill_we_q;
  assign fill_tag   = fill_tag_q;
  assign fill_index = fill_index_q;
  assign fill_data  = fill_data_q;
  assign err        = err_q;

`ifdef REFILL_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;
  logic        replay_q;

  // The replayed access after a fill is part of the miss, so it is not counted as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      replay_q     <= 1'b0;
    end else if (state_q == IDLE && req_valid) begin
      if (hit) begin
        if (!replay_q) begin
          hit_count_q <= hit_count_q + 32'd1;
        end
        replay_q <= 1'b0;
      end else begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end else if (state_q == FILL) begin
      replay_q <= 1'b1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a transaction-level cache/memory model predicts
// accepts, line reads, fills and errors with cycle stamps; a negedge monitor checks them.
module tb_cache_refill_ctrl;

  localparam int TMO = 4;
`ifdef REFILL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [14:0]  req_addr = '0;
  logic         req_ready;
  logic         hit;
  logic         mem_rd;
  logic [12:0]  mem_addr;
  logic         mem_valid = 1'b0;
  logic [127:0] mem_data = '0;
  logic         fill_we;
  logic [2:0]   fill_tag;
  logic [9:0]   fill_index;
  logic [127:0] fill_data;
  logic         busy;
  logic         err;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  cache_refill_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .hit(hit), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .fill_we(fill_we), .fill_tag(fill_tag), .fill_index(fill_index), .fill_data(fill_data),
    .busy(busy), .err(err), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Environment cache tag store, written by the DUT's fill strobe; drives the hit input.
  bit       ev[1024];
  bit [2:0] etag[1024];
  assign hit = ev[req_addr[11:2]] && (etag[req_addr[11:2]] == req_addr[14:12]);
  always @(posedge clk) begin
    if (fill_we) begin
      ev[fill_index]   <= 1'b1;
      etag[fill_index] <= fill_tag;
    end
  end

  // Expected-event queues.
  typedef struct { int cyc; logic [14:0] addr; } acc_t;
  typedef struct { int rise; int fall; logic [12:0] addr; } rd_t;
  typedef struct { int cyc; logic [2:0] tag; logic [9:0] idx; logic [127:0] data; } fill_t;
  acc_t  acc_q[$];
  rd_t   rd_q[$];
  fill_t fill_q[$];
  int    err_q[$];

  // Reference model state.
  bit       m_val[1024];
  bit [2:0] m_tag[1024];
  int       m_hits = 0;
  int       m_miss = 0;
  bit       m_replay = 1'b0;
  bit       m_err = 1'b0;

  // Monitor.
  bit    mon_en = 1'b0;
  logic  rd_prev = 1'b0;
  logic  err_prev = 1'b0;
  rd_t   cur_rd = '{0, 0, 13'd0};
  acc_t  a;
  fill_t f;
  int    e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_valid && req_ready) begin
        if (acc_q.size() == 0) chk("unexpected_accept", 128'(req_ready), 128'(0));
        else begin
          a = acc_q.pop_front();
          chk("accept_cycle", 128'(cyc), 128'(a.cyc));
          chk("accept_addr", 128'(req_addr), 128'(a.addr));
        end
      end
      if (mem_rd && !rd_prev) begin
        if (rd_q.size() == 0) chk("unexpected_mem_rd", 128'(mem_rd), 128'(0));
        else begin
          cur_rd = rd_q.pop_front();
          chk("mem_rd_rise_cycle", 128'(cyc), 128'(cur_rd.rise));
        end
      end
      if (mem_rd) chk("mem_addr_hold", 128'(mem_addr), 128'(cur_rd.addr));
      if (!mem_rd && rd_prev) chk("mem_rd_fall_cycle", 128'(cyc), 128'(cur_rd.fall));
      if (fill_we) begin
        if (fill_q.size() == 0) chk("unexpected_fill", 128'(fill_we), 128'(0));
        else begin
          f = fill_q.pop_front();
          chk("fill_cycle", 128'(cyc), 128'(f.cyc));
          chk("fill_tag", 128'(fill_tag), 128'(f.tag));
          chk("fill_index", 128'(fill_index), 128'(f.idx));
          chk("fill_data", fill_data, f.data);
        end
      end
      if (err && !err_prev) begin
        if (err_q.size() == 0) chk("unexpected_err", 128'(err), 128'(0));
        else begin
          e = err_q.pop_front();
          chk("err_cycle", 128'(cyc), 128'(e));
        end
      end
    end
    rd_prev  = mem_rd;
    err_prev = err;
  end

  task automatic adv(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Idle cycles: no request; stray mem_valid pulses must be ignored.
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      req_valid = 1'b0;
      req_addr  = 15'($urandom);
      mem_valid = ($urandom_range(0, 3) == 0);
      mem_data  = rand128();
      adv(1);
    end
    mem_valid = 1'b0;
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r < 8) return TMO;
    if (r == 8) return TMO + 1;
    return 0;
  endfunction

  // One request held until the model says it is accepted.
  // lat: FETCH cycle (0-based) in which memory answers; > TMO means no answer.
  task automatic issue(input logic [14:0] addr, input int lat, input logic [127:0] dfix, input bit use_fix);
    int t0, l;
    logic [9:0] idx;
    logic [2:0] tag;
    logic [127:0] d;
    idx = addr[11:2];
    tag = addr[14:12];
    req_valid = 1'b1;
    req_addr  = addr;
    for (int tries = 0; tries < 8; tries++) begin
      if (m_val[idx] && m_tag[idx] == tag) begin
        acc_q.push_back('{cyc, addr});
        if (!m_replay) m_hits++;
        m_replay = 1'b0;
        adv(1);
        req_valid = 1'b0;
        return;
      end
      m_miss++;
      t0 = cyc;
      if (tries == 0 && lat >= 0) l = lat;
      else if (tries >= 6) l = 0;
      else l = pick_lat();
      if (l <= TMO) begin
        d = use_fix ? dfix : rand128();
        rd_q.push_back('{t0 + 1, t0 + 2 + l, addr[14:2]});
        fill_q.push_back('{t0 + 2 + l, tag, idx, d});
        adv(1 + l);
        mem_valid = 1'b1;
        mem_data  = d;
        adv(1);
        mem_valid = 1'b0;
        m_val[idx] = 1'b1;
        m_tag[idx] = tag;
        m_replay   = 1'b1;
        adv(1);
      end else begin
        rd_q.push_back('{t0 + 1, t0 + 2 + TMO, addr[14:2]});
        if (!m_err) err_q.push_back(t0 + 2 + TMO);
        m_err = 1'b1;
        adv(2 + TMO);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hit_count"}, 128'(hit_count), STATS ? 128'(m_hits) : 128'(0));
    chk({tag, "_miss_count"}, 128'(miss_count), STATS ? 128'(m_miss) : 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [14:0] ra;
    rst = 1'b1;
    adv(3);
    rst = 1'b0;
    chk("reset_mem_rd", 128'(mem_rd), 128'(0));
    chk("reset_mem_addr", 128'(mem_addr), 128'(0));
    chk("reset_fill_we", 128'(fill_we), 128'(0));
    chk("reset_fill_data", fill_data, 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_err", 128'(err), 128'(0));
    chk_counts("reset");
    mon_en = 1'b1;

    // Directed miss on 15'h1A5D, memory answers 3 cycles after mem_rd rises; then 4 back-to-back hits.
    issue(15'h1A5D, 3, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 1'b1);
    chk_counts("first_miss");
    for (int i = 0; i < 4; i++) issue(15'h1A5D, -1, '0, 1'b0);
    chk_counts("four_hits");
    // Zero-wait memory, then a fresh hit.
    issue(15'h2008, 0, '0, 1'b0);
    issue(15'h2008, -1, '0, 1'b0);
    // Answer in the last FETCH cycle: memory wins over timeout.
    issue(15'h3010, TMO, '0, 1'b0);
    // No answer: timeout, err, replay misses again.
    issue(15'h4020, TMO + 1, '0, 1'b0);
    chk("timeout_err", 128'(err), 128'(1));
    chk_counts("after_timeout");

    for (int n = 0; n < 60; n++) begin
      idle(int'($urandom_range(0, 2)));
      ra = {3'($urandom_range(0, 1)), 8'd0, 2'($urandom_range(0, 3)), 2'($urandom)};
      issue(ra, -1, '0, 1'b0);
    end
    idle(3);
    chk_counts("random");
    chk("err_final", 128'(err), 128'(m_err));
    chk("accepts_pending", 128'(acc_q.size()), 128'(0));
    chk("mem_reads_pending", 128'(rd_q.size()), 128'(0));
    chk("fills_pending", 128'(fill_q.size()), 128'(0));
    chk("errs_pending", 128'(err_q.size()), 128'(0));

    // Reset mid-FETCH while memory answers in the same cycle.
    mon_en    = 1'b0;
    req_valid = 1'b1;
    req_addr  = 15'h7FFC;
    adv(2);
    chk("pre_reset_mem_rd", 128'(mem_rd), 128'(1));
    rst       = 1'b1;
    mem_valid = 1'b1;
    mem_data  = rand128();
    adv(1);
    rst       = 1'b0;
    mem_valid = 1'b0;
    req_valid = 1'b0;
    chk("midfetch_rst_mem_rd", 128'(mem_rd), 128'(0));
    chk("midfetch_rst_fill_we", 128'(fill_we), 128'(0));
    chk("midfetch_rst_busy", 128'(busy), 128'(0));
    chk("midfetch_rst_err", 128'(err), 128'(0));
    chk("midfetch_rst_hit_count", 128'(hit_count), 128'(0));
    chk("midfetch_rst_miss_count", 128'(miss_count), 128'(0));
    adv(1);
    chk("post_rst_fill_we", 128'(fill_we), 128'(0));
    chk("post_rst_mem_rd", 128'(mem_rd), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
